ines_loader: RTL and testbench
==============================

// Module: ines_loader
// PURPOSE
//  Writer side of cartridge memory: parses an iNES image byte stream and writes PRG/CHR ROM
//  into cart memories that mapper logic later reads. Produces the static cart configuration
//  (mirroring, CHR RAM, PRG RAM, address masks, mapper id) that mapper logic consumes.
//  Sits between the SD/UART image source and cart memories; mapper logic stays in reset until done=1.
// PARAMETERS
//  PRG_ROM_DEPTH  17  PRG ROM address bits (128 KiB)
//  CHR_ROM_DEPTH  15  CHR ROM/RAM address bits (32 KiB)
//  PRG_RAM_DEPTH  13  PRG RAM address bits (8 KiB)
// PORTS
//  clk_cpu      in   1    clock; all logic on rising edge
//  rst          in   1    reset, synchronous, active-low (0 = reset)
//  start        in   1    1-cycle pulse: begin/restart load
//  in_data      in   8    image byte
//  in_valid     in   1    in_data valid
//  in_ready     out  1    loader accepts byte; transfer when in_valid&in_ready
//  prg_wr       out  1    PRG ROM write strobe (1 cycle)
//  chr_wr       out  1    CHR write strobe (1 cycle)
//  wr_addr      out  max(PRG_ROM_DEPTH,CHR_ROM_DEPTH)  write address, zero-extended
//  wr_data      out  8    write data
//  mirrorv      out  1    flags6[0]
//  chr_ram      out  1    1 when header CHR bank count = 0
//  prg_ram      out  1    flags6[1]
//  prg_mask     out  PRG_ROM_DEPTH  PRG address mask
//  chr_mask     out  CHR_ROM_DEPTH  CHR address mask
//  prgram_mask  out  PRG_RAM_DEPTH  PRG RAM address mask
//  mapper_id    out  8    {flags7[7:4], flags6[7:4]}
//  done         out  1    image loaded, config valid; held until start/reset
//  error        out  1    load aborted; held until start/reset
// BEHAVIOUR
//  - Reset: state IDLE; in_ready, prg_wr, chr_wr, done, error, mirrorv, chr_ram, prg_ram = 0;
//    wr_addr, wr_data, mapper_id, all masks = 0.
//  - States: IDLE -start-> HEADER(16 B) -> [TRAINER(512 B) if flags6[2]] -> PRG -> CHR -> [CLEAR] -> DONE;
//    any check failure -> ERROR. start in any state (incl. mid-stream) -> HEADER, clears done/error/counters.
//  - in_ready=1 only in HEADER, TRAINER, PRG, CHR; 0 in IDLE, CLEAR, DONE, ERROR. in_valid ignored otherwise.
//  - Header checks at byte index 3 accept: bytes 0..3 must be 4E 45 53 1A, else ERROR.
//  - After byte 15: PRG bytes = byte4*16384, CHR bytes = byte5*8192 (counters wide enough for 255 banks).
//    byte4=0 -> ERROR; PRG bytes > 2^PRG_ROM_DEPTH -> ERROR; CHR bytes > 2^CHR_ROM_DEPTH -> ERROR.
//  - Masks: prg_mask = (next pow2 >= PRG bytes)-1; byte5=0 -> chr_ram=1, chr_mask=16'h1FFF truncated;
//    else chr_mask = (next pow2 >= CHR bytes)-1; prgram_mask = all ones (2^PRG_RAM_DEPTH-1) when prg_ram.
//    Config outputs update once, the cycle after byte 15 is accepted.
//  - Writes: accepted byte k of PRG section -> next cycle prg_wr=1, wr_addr=k, wr_data=byte (latency 1).
//    Same for CHR with chr_wr. Trainer bytes are consumed and discarded. Never prg_wr&chr_wr together.
//  - Section boundary: last PRG byte accepted -> CHR (or CLEAR/DONE if byte5=0) with no lost cycle;
//    back-to-back in_valid every cycle sustains 1 byte/cycle.
//  - byte5=0 with zero CHR section: CHR state skipped entirely.
//  - Stream bytes beyond expected length are not accepted (in_ready=0 in DONE).
//  - done/error are mutually exclusive; done asserts the cycle after the final write strobe.
// CONFIGURATION
//  CHR_RAM_CLEAR_EN defined: when chr_ram=1, state CLEAR issues 8192 chr_wr strobes, wr_addr 0..0x1FFF,
//    wr_data=0, one per cycle, then DONE (done 1 cycle after last strobe). in_ready=0 throughout.
//  Not defined: CLEAR state absent; chr_ram=1 goes straight to DONE; CHR RAM contents untouched.
// TESTING
//  - NROM-128: header 4E 45 53 1A 01 01 01 00 +8x00, 16384+8192 B -> 16384 prg_wr addr 0..3FFF,
//    8192 chr_wr addr 0..1FFF, mirrorv=1, prg_mask=0x3FFF, chr_mask=0x1FFF, mapper_id=0, done=1.
//  - Bad magic: 4E 45 53 1B ... -> error=1 after 4th byte, in_ready=0, no write strobes.
//  - Oversize: byte4=0x10 (256 KiB) with PRG_ROM_DEPTH=17 -> error=1 after byte 15, no prg_wr.
//  - Trainer+CHR RAM: flags6=0x04, byte4=2, byte5=0 -> 512 B skipped, 32768 prg_wr, prg_mask=0x7FFF,
//    chr_ram=1; with CHR_RAM_CLEAR_EN 8192 zero chr_wr before done, else done right after PRG.
//  - Throttled source: in_valid random 50% -> write sequence identical to back-to-back case.
//  - start pulse mid-PRG, then full valid image -> addresses restart at 0, done=1, error=0;
//    rst=0 mid-CHR for 1 cycle -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES image byte stream, writes PRG/CHR ROM into cart
// memories and publishes the static cart configuration for mapper logic.
// Optional feature macro: CHR_RAM_CLEAR_EN (zero-fill CHR RAM before done).
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the current state, never on in_valid.
// state_dbg exposes the FSM state for checkers.
module ines_loader #(
    parameter int PRG_ROM_DEPTH = 17,
    parameter int CHR_ROM_DEPTH = 15,
    parameter int PRG_RAM_DEPTH = 13,
    localparam int AW = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     prg_wr,
    output logic                     chr_wr,
    output logic [AW-1:0]            wr_addr,
    output logic [7:0]               wr_data,
    output logic                     mirrorv,
    output logic                     chr_ram,
    output logic                     prg_ram,
    output logic [PRG_ROM_DEPTH-1:0] prg_mask,
    output logic [CHR_ROM_DEPTH-1:0] chr_mask,
    output logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic [7:0]               mapper_id,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               state_dbg
);

    // Byte counters must cover 255 banks of 16 KiB.
    localparam int CW = 22;
    localparam logic [CW:0] PRG_LIMIT = {{CW{1'b0}}, 1'b1} << PRG_ROM_DEPTH;
    localparam logic [CW:0] CHR_LIMIT = {{CW{1'b0}}, 1'b1} << CHR_ROM_DEPTH;
    localparam logic [CHR_ROM_DEPTH-1:0] CHR_RAM_MASK = CHR_ROM_DEPTH'(32'h1FFF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_TRAINER = 3'd2,
        S_PRG     = 3'd3,
        S_CHR     = 3'd4,
`ifdef CHR_RAM_CLEAR_EN
        S_CLEAR   = 3'd5,
`endif
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t        state;
    state_t        after_prg;
    logic [3:0]    hdr_cnt;
    logic [8:0]    trn_cnt;
    logic [CW-1:0] sec_cnt;
`ifdef CHR_RAM_CLEAR_EN
    logic [12:0]   clr_cnt;
`endif
    logic          magic_bad;
    logic [7:0]    prg_banks;
    logic [7:0]    chr_banks;
    logic          mirror_f;
    logic          prgram_f;
    logic          trainer_f;
    logic [3:0]    map_lo;
    logic [3:0]    map_hi;

    logic          fire;
    logic [CW-1:0] prg_bytes;
    logic [CW-1:0] chr_bytes;
    logic [CW-1:0] prg_last;
    logic [CW-1:0] chr_last;
    logic          prg_too_big;
    logic          chr_too_big;

    // Turns x into (next power of two above x) - 1 by smearing the top set bit down.
    function automatic logic [CW-1:0] smear(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            r = r | (r >> (1 << i));
        end
        return r;
    endfunction

    assign fire        = in_valid && in_ready;
    assign prg_bytes   = {prg_banks, 14'd0};
    assign chr_bytes   = {1'b0, chr_banks, 13'd0};
    assign prg_last    = prg_bytes - CW'(1);
    assign chr_last    = chr_bytes - CW'(1);
    assign prg_too_big = {1'b0, prg_bytes} > PRG_LIMIT;
    assign chr_too_big = {1'b0, chr_bytes} > CHR_LIMIT;

    // Status decoded straight from the state register.
    assign in_ready  = (state == S_HEADER) || (state == S_TRAINER) ||
                       (state == S_PRG)    || (state == S_CHR);
    assign error     = (state == S_ERROR);
    assign state_dbg = state;

    // Where the stream goes once the last PRG byte is taken.
    always_comb begin
        after_prg = S_DONE;
        if (chr_banks != 8'd0)
            after_prg = S_CHR;
`ifdef CHR_RAM_CLEAR_EN
        else
            after_prg = S_CLEAR;
`endif
    end

    // Loader FSM: header parse, section sequencing, write strobes and config.
    always_ff @(posedge clk_cpu) begin
        if (!rst) begin
            state       <= S_IDLE;
            hdr_cnt     <= 4'd0;
            trn_cnt     <= 9'd0;
            sec_cnt     <= '0;
`ifdef CHR_RAM_CLEAR_EN
            clr_cnt     <= 13'd0;
`endif
            magic_bad   <= 1'b0;
            prg_banks   <= 8'd0;
            chr_banks   <= 8'd0;
            mirror_f    <= 1'b0;
            prgram_f    <= 1'b0;
            trainer_f   <= 1'b0;
            map_lo      <= 4'd0;
            map_hi      <= 4'd0;
            prg_wr      <= 1'b0;
            chr_wr      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'd0;
            mirrorv     <= 1'b0;
            chr_ram     <= 1'b0;
            prg_ram     <= 1'b0;
            prg_mask    <= '0;
            chr_mask    <= '0;
            prgram_mask <= '0;
            mapper_id   <= 8'd0;
            done        <= 1'b0;
        end else begin
            prg_wr <= 1'b0;
            chr_wr <= 1'b0;
            if (start) begin
                // Restart wins over any in-flight byte.
                state     <= S_HEADER;
                hdr_cnt   <= 4'd0;
                trn_cnt   <= 9'd0;
                sec_cnt   <= '0;
`ifdef CHR_RAM_CLEAR_EN
                clr_cnt   <= 13'd0;
`endif
                magic_bad <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    S_HEADER: if (fire) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        case (hdr_cnt)
                            4'd0: magic_bad <= (in_data != 8'h4E);
                            4'd1: magic_bad <= magic_bad | (in_data != 8'h45);
                            4'd2: magic_bad <= magic_bad | (in_data != 8'h53);
                            4'd3: if (magic_bad || (in_data != 8'h1A)) state <= S_ERROR;
                            4'd4: prg_banks <= in_data;
                            4'd5: chr_banks <= in_data;
                            4'd6: begin
                                mirror_f  <= in_data[0];
                                prgram_f  <= in_data[1];
                                trainer_f <= in_data[2];
                                map_lo    <= in_data[7:4];
                            end
                            4'd7: map_hi <= in_data[7:4];
                            4'd15: begin
                                mirrorv     <= mirror_f;
                                prg_ram     <= prgram_f;
                                chr_ram     <= (chr_banks == 8'd0);
                                prg_mask    <= PRG_ROM_DEPTH'(smear(prg_last));
                                chr_mask    <= (chr_banks == 8'd0) ? CHR_RAM_MASK
                                                                   : CHR_ROM_DEPTH'(smear(chr_last));
                                prgram_mask <= prgram_f ? '1 : '0;
                                mapper_id   <= {map_hi, map_lo};
                                sec_cnt     <= '0;
                                trn_cnt     <= 9'd0;
                                if ((prg_banks == 8'd0) || prg_too_big || chr_too_big)
                                    state <= S_ERROR;
                                else if (trainer_f)
                                    state <= S_TRAINER;
                                else
                                    state <= S_PRG;
                            end
                            default: ;
                        endcase
                    end
                    S_TRAINER: if (fire) begin
                        trn_cnt <= trn_cnt + 9'd1;
                        if (trn_cnt == 9'h1FF)
                            state <= S_PRG;
                    end
                    S_PRG: if (fire) begin
                        prg_wr  <= 1'b1;
                        wr_addr <= sec_cnt[AW-1:0];
                        wr_data <= in_data;
                        if (sec_cnt == prg_last) begin
                            sec_cnt <= '0;
                            state   <= after_prg;
                        end else begin
                            sec_cnt <= sec_cnt + CW'(1);
                        end
                    end
                    S_CHR: if (fire) begin
                        chr_wr  <= 1'b1;
                        wr_addr <= sec_cnt[AW-1:0];
                        wr_data <= in_data;
                        if (sec_cnt == chr_last) begin
                            sec_cnt <= '0;
                            state   <= S_DONE;
                        end else begin
                            sec_cnt <= sec_cnt + CW'(1);
                        end
                    end
`ifdef CHR_RAM_CLEAR_EN
                    S_CLEAR: begin
                        chr_wr  <= 1'b1;
                        wr_addr <= AW'(clr_cnt);
                        wr_data <= 8'd0;
                        clr_cnt <= clr_cnt + 13'd1;
                        if (clr_cnt == 13'h1FFF)
                            state <= S_DONE;
                    end
`endif
                    // done follows the final strobe by one cycle.
                    S_DONE: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: randomized image streams checked against an iNES layout model.
module tb_ines_loader;

    localparam int AW = 17;
    localparam int EW = 2 + AW + 8;

    logic          clk_cpu = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          prg_wr;
    logic          chr_wr;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          mirrorv;
    logic          chr_ram;
    logic          prg_ram;
    logic [16:0]   prg_mask;
    logic [14:0]   chr_mask;
    logic [12:0]   prgram_mask;
    logic [7:0]    mapper_id;
    logic          done;
    logic          error;
    logic [2:0]    state_dbg;

    ines_loader dut (
        .clk_cpu(clk_cpu), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .prg_wr(prg_wr), .chr_wr(chr_wr),
        .wr_addr(wr_addr), .wr_data(wr_data), .mirrorv(mirrorv), .chr_ram(chr_ram),
        .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .prgram_mask(prgram_mask), .mapper_id(mapper_id), .done(done), .error(error),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk_cpu = ~clk_cpu;

    int             checks = 0;
    int             failures = 0;
    longint         cyc = 0;
    longint         last_wr_cyc = -100;
    logic           done_q = 1'b0;
    logic [EW-1:0]  exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int np2(input int n);
        int p = 1;
        while (p < n) p = p * 2;
        return p;
    endfunction

    // Scoreboard monitor: every write strobe pops one expected write.
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_cpu);
            cyc++;
            if (prg_wr && chr_wr) check("strobe_exclusive", {prg_wr, chr_wr}, 2'b00);
            if (prg_wr || chr_wr) begin
                got = {prg_wr, chr_wr, wr_addr, wr_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write got=%0h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("write", got, e);
                end
                last_wr_cyc = cyc;
            end
            if (done && !done_q) begin
                check("done_after_last_strobe", cyc - last_wr_cyc, 1);
                check("done_error_exclusive", error, 0);
            end
            done_q = done;
        end
    end

    // Driver: offer one byte, optional random idle cycles first (about 50% valid).
    task automatic send_byte(input logic [7:0] b, input bit throttle, input bit has_exp,
                             input logic [EW-1:0] e, output bit ok);
        int w = 0;
        if (throttle) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(negedge clk_cpu);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 64) begin
            @(negedge clk_cpu);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout got=in_ready0 exp=in_ready1");
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        if (has_exp) exp_q.push_back(e);
        ok = 1'b1;
        @(negedge clk_cpu);
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] f6,
                               input logic [7:0] f7, input bit throttle, output bit ok);
        logic [7:0] h[16];
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
        h[4] = b4;    h[5] = b5;    h[6] = f6;    h[7] = f7;
        for (int i = 8; i < 16; i++) h[i] = 8'($urandom);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(h[i], throttle, 1'b0, '0, ok);
            if (!ok) return;
        end
    endtask

    // Model of the image body: trainer discarded, PRG then CHR written from address 0.
    task automatic send_body(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] f6,
                             input bit throttle, input int limit, output bit ok);
        int sent = 0;
        int nprg = int'(b4) * 16384;
        int nchr = int'(b5) * 8192;
        logic [7:0] d;
        ok = 1'b1;
        if (f6[2]) begin
            for (int i = 0; i < 512; i++) begin
                send_byte(8'($urandom), throttle, 1'b0, '0, ok);
                if (!ok) return;
            end
        end
        for (int k = 0; k < nprg; k++) begin
            if (limit >= 0 && sent >= limit) return;
            d = 8'($urandom);
            send_byte(d, throttle, 1'b1, {2'b10, AW'(k), d}, ok);
            sent++;
            if (!ok) return;
        end
`ifdef CHR_RAM_CLEAR_EN
        if (nchr == 0) begin
            for (int k = 0; k < 8192; k++) exp_q.push_back({2'b01, AW'(k), 8'h00});
        end
`endif
        for (int k = 0; k < nchr; k++) begin
            if (limit >= 0 && sent >= limit) return;
            d = 8'($urandom);
            send_byte(d, throttle, 1'b1, {2'b01, AW'(k), d}, ok);
            sent++;
            if (!ok) return;
        end
    endtask

    task automatic check_config(input string tag, input logic [7:0] b4, input logic [7:0] b5,
                                input logic [7:0] f6, input logic [7:0] f7);
        int pm = np2(int'(b4) * 16384) - 1;
        int cm = (b5 == 8'd0) ? 32'h1FFF : np2(int'(b5) * 8192) - 1;
        check({tag, "_mirrorv"}, mirrorv, f6[0]);
        check({tag, "_prg_ram"}, prg_ram, f6[1]);
        check({tag, "_chr_ram"}, chr_ram, (b5 == 8'd0));
        check({tag, "_prg_mask"}, prg_mask, pm);
        check({tag, "_chr_mask"}, chr_mask, cm);
        check({tag, "_prgram_mask"}, prgram_mask, f6[1] ? 13'h1FFF : 13'h0);
        check({tag, "_mapper_id"}, mapper_id, {f7[7:4], f6[7:4]});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_prg_wr"}, prg_wr, 0);
        check({tag, "_chr_wr"}, chr_wr, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_mirrorv"}, mirrorv, 0);
        check({tag, "_chr_ram"}, chr_ram, 0);
        check({tag, "_prg_ram"}, prg_ram, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_mapper_id"}, mapper_id, 0);
        check({tag, "_prg_mask"}, prg_mask, 0);
        check({tag, "_chr_mask"}, chr_mask, 0);
        check({tag, "_prgram_mask"}, prgram_mask, 0);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int w = 0;
        while (!done && !error && w < 20000) begin
            @(negedge clk_cpu);
            w++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        logic [7:0] f6;
        logic [7:0] f7;

        // Reset
        rst = 1'b0;
        repeat (3) @(negedge clk_cpu);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk_cpu);
        check("idle_in_ready", in_ready, 0);

        // Abort mid-PRG with start, then a full NROM-128 image back-to-back
        pulse_start();
        send_header(8'd1, 8'd1, 8'h01, 8'h00, 1'b0, ok);
        send_body(8'd1, 8'd1, 8'h01, 1'b0, 300, ok);
        pulse_start();
        @(negedge clk_cpu);
        check("restart_queue_empty", exp_q.size(), 0);
        check("restart_in_ready", in_ready, 1);
        send_header(8'd1, 8'd1, 8'h01, 8'h00, 1'b0, ok);
        send_body(8'd1, 8'd1, 8'h01, 1'b0, -1, ok);
        wait_end("nrom");
        check_config("nrom", 8'd1, 8'd1, 8'h01, 8'h00);
        @(negedge clk_cpu);
        check("nrom_done_held", done, 1);

        // Bad magic: error after the fourth byte
        pulse_start();
        check("start_clears_done", done, 0);
        send_byte(8'h4E, 1'b0, 1'b0, '0, ok);
        send_byte(8'h45, 1'b0, 1'b0, '0, ok);
        send_byte(8'h53, 1'b0, 1'b0, '0, ok);
        send_byte(8'h1B, 1'b0, 1'b0, '0, ok);
        check("badmagic_error", error, 1);
        check("badmagic_in_ready", in_ready, 0);
        check("badmagic_done", done, 0);

        // Size checks: oversize PRG, zero PRG, oversize CHR
        pulse_start();
        check("start_clears_error", error, 0);
        send_header(8'h10, 8'd1, 8'h00, 8'h00, 1'b0, ok);
        check("oversize_prg_error", error, 1);
        check("oversize_prg_in_ready", in_ready, 0);
        pulse_start();
        send_header(8'h00, 8'd1, 8'h00, 8'h00, 1'b0, ok);
        check("zero_prg_error", error, 1);
        pulse_start();
        send_header(8'd1, 8'd5, 8'h00, 8'h00, 1'b0, ok);
        check("oversize_chr_error", error, 1);

        // Largest legal sizes and non-power-of-two masks (header only, then abort)
        pulse_start();
        send_header(8'd8, 8'd4, 8'h10, 8'h20, 1'b0, ok);
        check("maxsize_error", error, 0);
        check("maxsize_in_ready", in_ready, 1);
        check_config("maxsize", 8'd8, 8'd4, 8'h10, 8'h20);
        pulse_start();
        f6 = {4'($urandom), 4'b0011};
        f7 = {4'($urandom), 4'b0000};
        send_header(8'd3, 8'd3, f6, f7, 1'b0, ok);
        check_config("odd", 8'd3, 8'd3, f6, f7);
        pulse_start();
        send_header(8'd2, 8'd0, 8'h00, 8'h00, 1'b0, ok);
        check_config("two_bank", 8'd2, 8'd0, 8'h00, 8'h00);
        pulse_start();
        check("abort_queue_empty", exp_q.size(), 0);

        // Trainer skipped, CHR RAM (no CHR section)
        f6 = {4'($urandom), 4'b0110};
        f7 = {4'($urandom), 4'b0000};
        send_header(8'd1, 8'd0, f6, f7, 1'b0, ok);
        send_body(8'd1, 8'd0, f6, 1'b0, -1, ok);
        wait_end("trainer");
        check_config("trainer", 8'd1, 8'd0, f6, f7);

        // Throttled source, reset pulse in the middle of CHR
        pulse_start();
        f6 = {4'($urandom), 4'b0001};
        f7 = {4'($urandom), 4'b0000};
        send_header(8'd1, 8'd1, f6, f7, 1'b1, ok);
        send_body(8'd1, 8'd1, f6, 1'b1, 16384 + 200, ok);
        check_config("throttled", 8'd1, 8'd1, f6, f7);
        rst = 1'b0;
        @(negedge clk_cpu);
        rst = 1'b1;
        check_reset_vals("midchr_reset");
        @(negedge clk_cpu);
        check("midchr_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
